// File: rtl/alu_seq.sv
// Registered ALU: single-cycle add/sub/logic/compare plus iterative shift-add
// multiply and restoring divide behind a start/busy/done handshake.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int OPW   = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             carry,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             dbz,
    output logic             illegal
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
    localparam logic [OPW-1:0] OP_DIV  = OPW'(3);
    localparam logic [OPW-1:0] OP_AND  = OPW'(4);
    localparam logic [OPW-1:0] OP_NAND = OPW'(5);
    localparam logic [OPW-1:0] OP_OR   = OPW'(6);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(7);
    localparam logic [OPW-1:0] OP_CMP  = OPW'(8);
    localparam logic [OPW-1:0] OP_NOT  = OPW'(9);

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_b;

    logic               r_done;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_result_hi;
    logic               r_carry;
    logic               r_ovf;
    logic               r_zero;
    logic               r_neg;
    logic               r_dbz;
    logic               r_illegal;

    logic [WIDTH:0]     w_add;
    logic [WIDTH:0]     w_sub;
    logic [2*WIDTH-1:0] w_acc_nx;
    logic [WIDTH:0]     w_dsh;
    logic [WIDTH:0]     w_dtr;
    logic [WIDTH-1:0]   w_rem_nx;
    logic [WIDTH-1:0]   w_quo_nx;
    logic               w_last;

    logic               w_fin;
    logic [WIDTH-1:0]   w_res;
    logic [WIDTH-1:0]   w_hi;
    logic               w_c;
    logic               w_v;
    logic               w_dbz;
    logic               w_ill;
    logic [1:0]         w_nstate;

    assign w_add = {1'b0, a} + {1'b0, b};
    assign w_sub = {1'b0, a} - {1'b0, b};

    // r_q holds the multiplier (shifted right) during MUL and the dividend/quotient during DIV
    assign w_acc_nx = r_q[0] ? (r_acc + r_mc) : r_acc;
    assign w_dsh    = {r_rem, r_q[WIDTH-1]};
    assign w_dtr    = w_dsh - {1'b0, r_b};
    assign w_rem_nx = w_dtr[WIDTH] ? w_dsh[WIDTH-1:0] : w_dtr[WIDTH-1:0];
    assign w_quo_nx = {r_q[WIDTH-2:0], ~w_dtr[WIDTH]};
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_fin    = 1'b0;
        w_res    = '0;
        w_hi     = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        w_dbz    = 1'b0;
        w_ill    = 1'b0;
        w_nstate = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_fin = 1'b1;
                    case (op)
                        OP_ADD: begin
                            w_res = w_add[WIDTH-1:0];
                            w_c   = w_add[WIDTH];
                            w_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_SUB: begin
                            w_res = w_sub[WIDTH-1:0];
                            w_c   = w_sub[WIDTH];
                            w_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
                        end
                        OP_MUL: begin
                            w_fin    = 1'b0;
                            w_nstate = S_MUL;
                        end
                        OP_DIV: begin
                            if (b == '0) begin
                                w_res = '1;
                                w_hi  = a;
                                w_dbz = 1'b1;
                            end else begin
                                w_fin    = 1'b0;
                                w_nstate = S_DIV;
                            end
                        end
                        OP_AND:  w_res = a & b;
                        OP_NAND: w_res = ~(a & b);
                        OP_OR:   w_res = a | b;
                        OP_XOR:  w_res = a ^ b;
                        OP_CMP:  w_res = (a > b) ? WIDTH'(1) : ((a < b) ? '1 : '0);
                        OP_NOT:  w_res = ~a;
                        default: w_ill = 1'b1;
                    endcase
                end
            end
            S_MUL: begin
                if (w_last) begin
                    w_fin    = 1'b1;
                    w_res    = w_acc_nx[WIDTH-1:0];
                    w_hi     = w_acc_nx[2*WIDTH-1:WIDTH];
                    w_c      = |w_acc_nx[2*WIDTH-1:WIDTH];
                    w_nstate = S_IDLE;
                end
            end
            S_DIV: begin
                if (w_last) begin
                    w_fin    = 1'b1;
                    w_res    = w_quo_nx;
                    w_hi     = w_rem_nx;
                    w_nstate = S_IDLE;
                end
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_mc        <= '0;
            r_q         <= '0;
            r_rem       <= '0;
            r_b         <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_result_hi <= '0;
            r_carry     <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
            r_neg       <= 1'b0;
            r_dbz       <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_done  <= w_fin;
            if (w_fin) begin
                r_result    <= w_res;
                r_result_hi <= w_hi;
                r_carry     <= w_c;
                r_ovf       <= w_v;
                r_zero      <= (w_res == '0);
                r_neg       <= w_res[WIDTH-1];
                r_dbz       <= w_dbz;
                r_illegal   <= w_ill;
            end
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
                if (start) begin
                    r_acc <= '0;
                    r_mc  <= {{WIDTH{1'b0}}, a};
                    r_q   <= (op == OP_MUL) ? b : a;
                    r_rem <= '0;
                    r_b   <= b;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
                if (r_state == S_MUL) begin
                    r_acc <= w_acc_nx;
                    r_mc  <= r_mc << 1;
                    r_q   <= r_q >> 1;
                end else begin
                    r_rem <= w_rem_nx;
                    r_q   <= w_quo_nx;
                end
            end
        end
    end

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign carry     = r_carry;
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;
    assign dbz       = r_dbz;
    assign illegal   = r_illegal;

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered arithmetic/logic unit that succeeds the combinational 8-bit ALU in the processor datapath. Single-cycle operations (add, sub, logic, compare, not) complete in one clock. Multiply and divide run iteratively over WIDTH cycles, using shift-add and restoring division respectively. A start/busy/done handshake lets the control unit stall on long operations; results and status flags are held in registers until the next accepted command.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥ 4)
- OPW, 5, opcode width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset: synchronous, active-high; one clock for the whole block
- start  in  1  command request, sampled only when busy=0
- op  in  OPW  opcode, latched on acceptance. Encodings: ADD=0, SUB=1, MUL=2, DIV=3, AND=4, NAND=5, OR=6, XOR=7, CMP=8, NOT=9; all others are illegal
- a  in  WIDTH  operand 1, latched on acceptance
- b  in  WIDTH  operand 2, latched on acceptance
- busy  out  1  high while MUL/DIV is iterating
- done  out  1  one-cycle pulse when result/flags are updated
- result  out  WIDTH  low word / quotient / main result
- result_hi  out  WIDTH  MUL high word, DIV remainder, else 0
- carry  out  1  ADD carry-out; SUB borrow (a<b unsigned); MUL result_hi≠0; else 0
- ovf  out  1  signed overflow for ADD/SUB, else 0
- zero  out  1  result==0
- neg  out  1  result[WIDTH-1]
- dbz  out  1  DIV with b==0
- illegal  out  1  unrecognised opcode

## Operation
- States are IDLE, MUL_RUN, DIV_RUN.
- Command acceptance: start=1 and busy=0 at a rising edge. This includes the cycle in which done is high, so back-to-back commands are allowed.
- Single-cycle ops: update outputs at the accepting edge; state stays IDLE.
  - ADD/SUB: computed mod 2^WIDTH.
  - AND/NAND/OR/XOR/NOT: NOT uses a only.
  - CMP (unsigned): result=1 if a>b, all-ones (−1) if a<b, 0 if equal.
- MUL (unsigned): latch operands and clear the accumulator; go to MUL_RUN. Run WIDTH iterations of shift-add on the 2·WIDTH-bit product, with an iteration counter of width clog2(WIDTH+1).
- DIV (unsigned, restoring): latch operands and go to DIV_RUN. Each iteration shifts the remainder left, trial-subtracts b, and sets one quotient bit, MSB first; WIDTH iterations in total.
- DIV by zero: does not enter DIV_RUN. Completes as a single-cycle op with result=all-ones, result_hi=a, dbz=1, carry=0.
- On leaving MUL_RUN/DIV_RUN: write result/result_hi/flags, pulse done, return to IDLE.
- Illegal opcode: single-cycle completion with result=0, result_hi=0, illegal=1, all other flags 0 except zero=1.
- Every completion recomputes all flags; flags not listed for that op are cleared.
- Outputs hold their values until the next completion. Internal iteration registers are not visible on the outputs mid-operation.
- start while busy=1: ignored, with no effect on the operation in progress or on the latched operands.
- Input changes after acceptance have no effect.

## Timing
- Reset (rst=1 at an edge): state=IDLE, counter=0, busy=0, done=0, and every output = 0. This applies mid-MUL/DIV too; the operation is aborted and no done is issued.
- Single-cycle op accepted at edge T: done=1 and new outputs visible during cycle T+1; busy stays 0.
- MUL, or DIV with b≠0, accepted at edge T:
  - busy=1 during cycles T+1 … T+WIDTH.
  - done=1, busy=0, and new outputs visible during cycle T+WIDTH+1.
  - Latency is WIDTH+1 edges to the done pulse (9 for WIDTH=8).
- done is never high for two consecutive cycles unless a new command was accepted in the done cycle.
- A start asserted in the same cycle as rst is dropped.

## Test plan
- WIDTH=8, ADD a=200 b=100 → result=44, carry=1, ovf=0, done at T+1. Then SUB a=5 b=7 → result=0xFE, carry=1, neg=1.
- ADD a=0x7F b=0x01 → result=0x80, ovf=1, neg=1, carry=0. Then CMP a=3 b=9 → result=0xFF; CMP a=9 b=9 → result=0, zero=1.
- MUL a=200 b=3 → busy high for exactly 8 cycles, then result=0x58, result_hi=0x02, carry=1, done at T+9. Hold start=1 with different operands throughout: no effect.
- DIV a=100 b=7 → result=14, result_hi=2, done at T+9. Then DIV a=100 b=0 → result=0xFF, result_hi=100, dbz=1, done at T+1, busy never high.
- Assert rst during cycle T+4 of a MUL → next cycle all outputs 0, busy=0, no done pulse. A following ADD 1+1 → result=2 at T'+1.
- op=31 → illegal=1, result=0, zero=1. Re-run at WIDTH=16 with MUL 0xFFFF×0xFFFF → result=0x0001, result_hi=0xFFFE, done at T+17.
